// File: rtl/imm_ext_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_ext_pkg : extension-mode codes and skid-buffer state encodings
// Revision    : 1.0
// ---------------------------------------------------------------------------
package imm_ext_pkg;

    localparam logic [1:0] IMM_SIGN = 2'd0;
    localparam logic [1:0] IMM_ZERO = 2'd1;
    localparam logic [1:0] IMM_HIGH = 2'd2;
    localparam logic [1:0] IMM_SHL2 = 2'd3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

endpackage : imm_ext_pkg
`default_nettype wire

// File: rtl/imm_ext_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_ext_core : combinational IN_W -> OUT_W immediate extender (4 modes)
// Revision     : 1.0
// ---------------------------------------------------------------------------
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm_i,
    input  logic [1:0]       mode_i,
    output logic [OUT_W-1:0] data_o
);

    logic [OUT_W-1:0] w_sign;

    assign w_sign = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};

    always_comb begin
        data_o = w_sign;
        case (mode_i)
            IMM_SIGN: data_o = w_sign;
            IMM_ZERO: data_o = {{(OUT_W-IN_W){1'b0}}, imm_i};
            IMM_HIGH: data_o = {imm_i, {(OUT_W-IN_W){1'b0}}};
            IMM_SHL2: data_o = w_sign << 2;
            default:  data_o = w_sign;
        endcase
    end

endmodule : imm_ext_core
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_extend_pipe : immediate extender behind a 2-entry valid/ready skid buffer
//                   Optional IMM_EXT_CNT_EN adds a 16-bit accepted-beat counter.
// Revision        : 1.0
// ---------------------------------------------------------------------------
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef IMM_EXT_CNT_EN
    ,
    output logic [15:0]      out_count
`endif
);

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [OUT_W-1:0] main_data_q;
    logic [TAG_W-1:0] main_tag_q;
    logic [OUT_W-1:0] skid_data_q;
    logic [TAG_W-1:0] skid_tag_q;

    logic [OUT_W-1:0] w_ext;
    logic             w_accept;
    logic             w_deliver;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm_i  (in_imm),
        .mode_i (in_mode),
        .data_o (w_ext)
    );

    assign w_accept  = in_valid && in_ready_q;
    assign w_deliver = out_valid_q && out_ready;

    // Main register always drives the outputs; skid only fills while main is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_data_q <= '0;
            main_tag_q  <= '0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
        end else if (flush) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_accept) begin
                        main_data_q <= w_ext;
                        main_tag_q  <= in_tag;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_deliver) begin
                        main_data_q <= w_ext;
                        main_tag_q  <= in_tag;
                    end else if (w_accept) begin
                        skid_data_q <= w_ext;
                        skid_tag_q  <= in_tag;
                        in_ready_q  <= 1'b0;
                        state_q     <= ST_TWO;
                    end else if (w_deliver) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_deliver) begin
                        main_data_q <= skid_data_q;
                        main_tag_q  <= skid_tag_q;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_ONE;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign out_tag   = main_tag_q;

`ifdef IMM_EXT_CNT_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign cnt_d = (w_accept && !flush) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_count = cnt_q;
`endif

endmodule : imm_extend_pipe
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_imm_extend_pipe : randomized + directed bench against a queue-based model
// Revision           : 1.0
// ---------------------------------------------------------------------------
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_imm = '0;
    logic [1:0]  in_mode = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
`ifdef IMM_EXT_CNT_EN
    logic [15:0] out_count;
`endif

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
`ifdef IMM_EXT_CNT_EN
        ,
        .out_count (out_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  t;
    } ent_t;

    ent_t        q[$];
    int unsigned cnt_m = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] md);
        logic [31:0] z;
        logic [31:0] s;
        z = {16'h0, imm};
        s = imm[15] ? (32'hFFFF_0000 | z) : z;
        case (md)
            2'd0:    return s;
            2'd1:    return z;
            2'd2:    return z * 32'd65536;
            default: return s * 32'd4;
        endcase
    endfunction

    task automatic check_outputs();
        chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
        chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
        if (q.size() > 0) begin
            chk("out_data", {32'd0, out_data}, {32'd0, q[0].d});
            chk("out_tag", {59'd0, out_tag}, {59'd0, q[0].t});
        end
`ifdef IMM_EXT_CNT_EN
        chk("out_count", {48'd0, out_count}, {48'd0, cnt_m[15:0]});
`endif
    endtask

    // One clock: check state left by the previous edge, drive, then advance the model.
    task automatic step(input logic v, input logic [15:0] imm, input logic [1:0] md,
                        input logic [4:0] tg, input logic ordy, input logic fl);
        bit acc;
        bit del;
        ent_t e;
        @(negedge clk);
        check_outputs();
        in_valid  = v;
        in_imm    = imm;
        in_mode   = md;
        in_tag    = tg;
        out_ready = ordy;
        flush     = fl;
        acc = v && (q.size() < 2);
        del = ordy && (q.size() > 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (del) void'(q.pop_front());
            if (acc) begin
                e.d = ref_ext(imm, md);
                e.t = tg;
                q.push_back(e);
                cnt_m++;
            end
        end
    endtask

    logic [31:0] sweep_exp [4];

    initial begin
        sweep_exp[0] = 32'hFFFF_8001;
        sweep_exp[1] = 32'h0000_8001;
        sweep_exp[2] = 32'h8001_0000;
        sweep_exp[3] = 32'hFFFE_0004;

        #12;
        rst = 1'b0;

        // Mode sweep, visible one cycle after accept
        for (int m = 0; m < 4; m++) begin
            step(1'b1, 16'h8001, m[1:0], m[4:0], 1'b1, 1'b0);
            #1;
            chk("sweep_data", {32'd0, out_data}, {32'd0, sweep_exp[m]});
        end
        step(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);

        // Back-to-back 8 beats
        for (int i = 0; i < 8; i++)
            step(1'b1, 16'($urandom), 2'($urandom), 5'(i), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++)
            step(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);

        // Stall: 3 offered, 2 taken, then drain
        for (int i = 0; i < 3; i++)
            step(1'b1, 16'h1234 + 16'(i), 2'd1, 5'(10 + i), 1'b0, 1'b0);
        #1;
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        chk("stall_head_tag", {59'd0, out_tag}, 64'd10);
        for (int i = 0; i < 3; i++)
            step(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);

        // Flush while full with a beat offered
        step(1'b1, 16'h0AAA, 2'd0, 5'd1, 1'b0, 1'b0);
        step(1'b1, 16'h0BBB, 2'd0, 5'd2, 1'b0, 1'b0);
        step(1'b1, 16'h0CCC, 2'd0, 5'd3, 1'b0, 1'b1);
        #1;
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 3; i++)
            step(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);

        // Async reset mid-stall
        step(1'b1, 16'h7777, 2'd3, 5'd4, 1'b0, 1'b0);
        step(1'b1, 16'h6666, 2'd2, 5'd5, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_data", {32'd0, out_data}, 64'd0);
        chk("rst_tag", {59'd0, out_tag}, 64'd0);
        q.delete();
        cnt_m = 0;
        #1;
        rst = 1'b0;
        step(1'b1, 16'hFFFF, 2'd0, 5'h1F, 1'b1, 1'b0);
        #1;
        chk("post_rst_tag", {59'd0, out_tag}, 64'h1F);
        chk("post_rst_data", {32'd0, out_data}, 64'hFFFF_FFFF);
        step(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom), 16'($urandom), 2'($urandom), 5'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        for (int i = 0; i < 3; i++)
            step(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);

`ifdef IMM_EXT_CNT_EN
        // Counter wrap: 0x10002 accepts plus one flushed beat
        @(negedge clk);
        rst = 1'b1;
        #1;
        q.delete();
        cnt_m = 0;
        rst = 1'b0;
        for (int i = 0; i < 32'h10002; i++)
            step(1'b1, 16'(i), 2'd0, 5'(i), 1'b1, 1'b0);
        step(1'b1, 16'h0, 2'd0, 5'd0, 1'b1, 1'b1);
        #1;
        chk("count_wrap", {48'd0, out_count}, 64'h0002);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_imm_extend_pipe
`default_nettype wire
